// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder_if
//  Purpose  : Bundles the host write port and the transmitter handshake of
//             uart_tx_feeder. The master modport belongs to the environment
//             (host and transmitter), and the slave modport belongs to the
//             feeder.
//  Options  : UART_TXF_OVF_EN adds the sticky overflow flag ovf and its
//             clear input ovf_clr.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_feeder_if #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
);
   logic              wr_en;
   logic [7:0]        wr_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              transmit;
   logic [7:0]        TxData;
   logic              busy;
   logic              tx_active;
`ifdef UART_TXF_OVF_EN
   logic              ovf;
   logic              ovf_clr;
`endif

   modport master (
`ifdef UART_TXF_OVF_EN
      output ovf_clr,
      input  ovf,
`endif
      output wr_en, wr_data, busy,
      input  full, empty, count, transmit, TxData, tx_active
   );

   modport slave (
`ifdef UART_TXF_OVF_EN
      input  ovf_clr,
      output ovf,
`endif
      input  wr_en, wr_data, busy,
      output full, empty, count, transmit, TxData, tx_active
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder
//  Purpose  : Synchronous byte FIFO in front of a UART transmitter. It pops one
//             byte at a time, sends it with a one-cycle transmit pulse, and then
//             waits for the busy signal to rise and fall before it sends the
//             next byte.
//  Options  : UART_TXF_OVF_EN adds a sticky overflow flag. The flag is set when
//             a write is dropped because the FIFO is full, and ovf_clr clears it.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  wire              clk,
   input  wire              reset,
   uart_tx_feeder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   c_cnt_full = (ADDR_W+1)'(DEPTH);

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   state_t            r_state;
   state_t            w_state_next;
   logic              r_transmit;
   logic              w_transmit_next;
   logic [7:0]        r_txdata;
   logic              w_full;
   logic              w_push;
   logic              w_pop;

   // The flags come only from the registered count. Because of this, a byte
   // written at one edge is not seen by the FSM until the next edge.
   assign w_full        = (r_count == c_cnt_full);
   assign w_push        = bus.wr_en && !w_full;
   assign bus.full      = w_full;
   assign bus.empty     = (r_count == '0);
   assign bus.count     = r_count;
   assign bus.transmit  = r_transmit;
   assign bus.TxData    = r_txdata;
   assign bus.tx_active = (r_state != IDLE);

   // FIFO storage. It is not reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.wr_data;
      end
   end

   // Pointers and occupancy. If a push and a pop happen in the same cycle,
   // both pointers advance and the count does not change.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   // State register, launch pulse, and the byte latched for the transmitter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_transmit <= 1'b0;
         r_txdata   <= 8'h00;
      end else begin
         r_state    <= w_state_next;
         r_transmit <= w_transmit_next;
         if (w_pop) begin
            r_txdata <= r_mem[r_rd_ptr];
         end
      end
   end

   // Next-state and launch decisions. In WAIT_BUSY, r_transmit is still high
   // during the first cycle. That cycle is skipped because the transmitter only
   // raises busy one edge after it samples the pulse. Skipping it also hides any
   // busy left over from a frame that was cut off by reset.
   always_comb begin
      w_state_next    = r_state;
      w_transmit_next = 1'b0;
      w_pop           = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_count != '0) begin
               w_pop           = 1'b1;
               w_transmit_next = 1'b1;
               w_state_next    = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!r_transmit && bus.busy) begin
               w_state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!bus.busy) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

`ifdef UART_TXF_OVF_EN
   logic r_ovf;

   // Sticky overflow flag. When a dropped write and a clear happen in the same
   // cycle, the set wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (bus.wr_en && w_full) begin
         r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign bus.ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_feeder
//  Purpose  : Self-checking bench for uart_tx_feeder. It includes a simple
//             transmitter model and a byte scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;
   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

   uart_tx_feeder #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_launch = 0;
   int         cyc      = 0;
   logic [7:0] exp_q[$];
   logic [7:0] sb_exp;
   logic       prev_tx   = 1'b0;
   logic       busy_m    = 1'b0;
   logic       hold_busy = 1'b0;
   int         busy_cnt  = 0;

   assign bus.busy = busy_m;

   // Cycle counter.
   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: busy rises one edge after transmit is sampled and
   // stays high for 10 cycles. hold_busy keeps it high past that point.
   always @(posedge clk) begin
      if (bus.transmit === 1'b1) begin
         busy_m   <= 1'b1;
         busy_cnt <= 10;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1 && !hold_busy) busy_m <= 1'b0;
      end else if (!hold_busy) begin
         busy_m <= 1'b0;
      end
   end

   // Scoreboard: each launch must carry the oldest expected byte and last
   // exactly one cycle.
   always @(negedge clk) begin
      if (bus.transmit === 1'b1) begin
         n_launch = n_launch + 1;
         n_checks = n_checks + 1;
         if (exp_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL sb_unexpected_launch: TxData=%02h, no byte expected", bus.TxData);
         end else begin
            sb_exp = exp_q.pop_front();
            if (bus.TxData !== sb_exp) begin
               n_fail = n_fail + 1;
               $display("FAIL sb_data: TxData=%02h expected %02h", bus.TxData, sb_exp);
            end
         end
         n_checks = n_checks + 1;
         if (prev_tx === 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL pulse_width: transmit high on two consecutive cycles, expected 1");
         end
      end
      prev_tx = bus.transmit;
   end

   task automatic test_reset();
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
`ifdef UART_TXF_OVF_EN
      bus.ovf_clr = 1'b0;
`endif
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
      n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.full); end
      n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
      n_checks++; if (bus.transmit !== 1'b0) begin n_fail++; $display("FAIL reset_transmit: got %b expected 0", bus.transmit); end
      n_checks++; if (bus.TxData !== 8'h00) begin n_fail++; $display("FAIL reset_txdata: got %02h expected 00", bus.TxData); end
      n_checks++; if (bus.tx_active !== 1'b0) begin n_fail++; $display("FAIL reset_tx_active: got %b expected 0", bus.tx_active); end
`ifdef UART_TXF_OVF_EN
      n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
`endif
      @(posedge clk); #1 reset = 1'b0;
   endtask

   task automatic test_single();
      int t0;
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.wr_data = 8'hA5; exp_q.push_back(8'hA5);
      @(posedge clk); #1 bus.wr_en = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", bus.count); end
      n_checks++; if (bus.transmit !== 1'b0) begin n_fail++; $display("FAIL single_no_fallthrough: transmit %b expected 0", bus.transmit); end
      @(negedge clk);
      n_checks++; if (bus.transmit !== 1'b1) begin n_fail++; $display("FAIL single_launch: transmit %b expected 1", bus.transmit); end
      n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", bus.count); end
      n_checks++; if (bus.tx_active !== 1'b1) begin n_fail++; $display("FAIL single_active: got %b expected 1", bus.tx_active); end
      t0 = cyc;
      for (int i = 0; i < 40 && bus.tx_active === 1'b1; i++) @(negedge clk);
      n_checks++; if (cyc - t0 != 12) begin n_fail++; $display("FAIL single_active_len: got %0d cycles expected 12", cyc - t0); end
      n_checks++; if (bus.TxData !== 8'hA5) begin n_fail++; $display("FAIL single_txdata_hold: got %02h expected a5", bus.TxData); end
   endtask

   task automatic test_burst();
      int fall_cyc = 0;
      int w;
      fork
         begin
            for (int i = 1; i <= 5; i++) begin
               @(posedge clk); #1;
               bus.wr_en = 1'b1; bus.wr_data = 8'(i); exp_q.push_back(8'(i));
            end
            @(posedge clk); #1 bus.wr_en = 1'b0;
         end
         begin
            for (int k = 0; k < 5; k++) begin
               w = 0;
               do begin @(negedge clk); w++; end while (bus.transmit !== 1'b1 && w < 200);
               n_checks++; if (w >= 200) begin n_fail++; $display("FAIL burst_launch_timeout: frame %0d not launched", k); end
               n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL burst_launch_busy: busy %b at launch, expected 0", busy_m); end
               if (k > 0) begin
                  n_checks++;
                  if (cyc - fall_cyc != 2) begin n_fail++; $display("FAIL burst_gap: got %0d cycles expected 2", cyc - fall_cyc); end
               end
               w = 0;
               do begin @(negedge clk); w++; end while (busy_m !== 1'b1 && w < 50);
               do begin @(negedge clk); w++; end while (busy_m !== 1'b0 && w < 100);
               fall_cyc = cyc;
            end
         end
      join
      for (int i = 0; i < 10 && bus.tx_active === 1'b1; i++) @(negedge clk);
      n_checks++; if (bus.empty !== 1'b1 || exp_q.size() != 0) begin n_fail++; $display("FAIL burst_drain: empty %b, %0d bytes outstanding, expected 1/0", bus.empty, exp_q.size()); end
   endtask

   task automatic test_full();
      hold_busy = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         @(posedge clk); #1;
         bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i);
         if (i <= DEPTH) exp_q.push_back(8'(8'h40 + i));
      end
      @(posedge clk); #1 bus.wr_en = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", bus.full); end
      n_checks++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d expected 16", bus.count); end
      n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", bus.empty); end
`ifdef UART_TXF_OVF_EN
      n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", bus.ovf); end
      repeat (2) @(negedge clk);
      n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.ovf); end
      @(posedge clk); #1 bus.ovf_clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
      @(posedge clk); #1 bus.ovf_clr = 1'b0; bus.wr_en = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", bus.ovf); end
      @(posedge clk); #1 bus.ovf_clr = 1'b1;
      @(posedge clk); #1 bus.ovf_clr = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", bus.ovf); end
      n_checks++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL full_count_hold: got %0d expected 16", bus.count); end
`endif
      hold_busy = 1'b0;
      for (int i = 0; i < 400 && !(bus.empty === 1'b1 && bus.tx_active === 1'b0); i++) @(negedge clk);
      n_checks++; if (bus.count !== 5'd0 || exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: count %0d, %0d bytes outstanding, expected 0/0", bus.count, exp_q.size()); end
   endtask

   task automatic test_wrap();
      int start;
      int w;
      start = n_launch;
      for (int g = 0; g < 4; g++) begin
         for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            bus.wr_en = 1'b1; bus.wr_data = 8'(g * 10 + j); exp_q.push_back(8'(g * 10 + j));
         end
         @(posedge clk); #1 bus.wr_en = 1'b0;
         w = 0;
         do begin @(negedge clk); w++; end while (bus.count > 5'd4 && w < 400);
         n_checks++; if (w >= 400) begin n_fail++; $display("FAIL wrap_pace_timeout: count %0d expected <= 4", bus.count); end
      end
      for (int i = 0; i < 200 && !(bus.empty === 1'b1 && bus.tx_active === 1'b0); i++) @(negedge clk);
      n_checks++; if (n_launch - start != 40) begin n_fail++; $display("FAIL wrap_launches: got %0d expected 40", n_launch - start); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_outstanding: got %0d expected 0", exp_q.size()); end
   endtask

   task automatic test_simul();
      hold_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.wr_en = 1'b1; bus.wr_data = 8'(8'hC0 + i); exp_q.push_back(8'(8'hC0 + i));
      end
      @(posedge clk); #1 bus.wr_en = 1'b0;
      repeat (20) @(posedge clk);
      #1 hold_busy = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.count !== 5'd3 || bus.tx_active !== 1'b1) begin n_fail++; $display("FAIL simul_pre: count %0d active %b expected 3/1", bus.count, bus.tx_active); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.wr_data = 8'hC4; exp_q.push_back(8'hC4);
      @(negedge clk);
      n_checks++; if (bus.count !== 5'd3 || bus.tx_active !== 1'b0) begin n_fail++; $display("FAIL simul_idle: count %0d active %b expected 3/0", bus.count, bus.tx_active); end
      @(posedge clk); #1 bus.wr_en = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.count !== 5'd3) begin n_fail++; $display("FAIL simul_count: got %0d expected 3", bus.count); end
      n_checks++; if (bus.transmit !== 1'b1) begin n_fail++; $display("FAIL simul_pop: transmit %b expected 1", bus.transmit); end
      for (int i = 0; i < 200 && !(bus.empty === 1'b1 && bus.tx_active === 1'b0); i++) @(negedge clk);
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_outstanding: got %0d expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      int l0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         bus.wr_en = 1'b1; bus.wr_data = 8'(8'hD0 + i);
         if (i == 0) exp_q.push_back(8'hD0);
      end
      @(posedge clk); #1 bus.wr_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.count !== 5'd4 || bus.tx_active !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: count %0d active %b expected 4/1", bus.count, bus.tx_active); end
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin n_fail++; $display("FAIL rmid_flush: empty %b count %0d expected 1/0", bus.empty, bus.count); end
      n_checks++; if (bus.transmit !== 1'b0 || bus.tx_active !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: transmit %b active %b expected 0/0", bus.transmit, bus.tx_active); end
      l0 = n_launch;
      repeat (25) @(negedge clk);
      n_checks++; if (n_launch != l0) begin n_fail++; $display("FAIL rmid_no_launch: got %0d launches expected 0", n_launch - l0); end
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.wr_data = 8'h77; exp_q.push_back(8'h77);
      @(posedge clk); #1 bus.wr_en = 1'b0;
      for (int i = 0; i < 100 && !(bus.empty === 1'b1 && bus.tx_active === 1'b0); i++) @(negedge clk);
      n_checks++; if (n_launch - l0 != 1 || exp_q.size() != 0) begin n_fail++; $display("FAIL rmid_resume: got %0d launches, %0d outstanding, expected 1/0", n_launch - l0, exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_full();
      test_wrap();
      test_simul();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
